pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline stage register, the successor to the fixed-field stall/clear stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload and a control payload across a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered. Control bits are forced to zero on bubbles and flushes, so downstream write enables never fire spuriously. It also provides a saturating back-pressure counter for performance debug.

---
 rtl/pipe_stage_skid_pkg.sv | 10 +
 rtl/pipe_slot.sv | 39 +++
 rtl/pipe_stage_skid.sv | 138 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared state encoding for the elastic skid stage
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PSK_EMPTY = 2'd0,
    PSK_ONE   = 2'd1,
    PSK_FULL  = 2'd2
  } psk_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register of the skid stage
module pipe_slot #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              drop,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // clear is the flush path; drop only retires the entry, so data lingers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end else if (drop) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage with two-entry skid buffer and registered in_ready
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  psk_state_t state, next_state;

  logic              in_xfer, out_xfer;
  logic              main_load, main_from_skid, main_drop;
  logic              skid_load, skid_drop;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic              in_ready_q;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid && out_ready;

  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state)
      PSK_EMPTY: begin
        if (in_xfer) begin
          next_state = PSK_ONE;
          main_load  = 1'b1;
        end
      end
      PSK_ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (out_xfer) begin
          next_state = PSK_EMPTY;
          main_drop  = 1'b1;
        end else if (in_xfer) begin
          next_state = PSK_FULL;
          skid_load  = 1'b1;
        end
      end
      PSK_FULL: begin
        if (out_xfer) begin
          next_state     = PSK_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end
      default: next_state = PSK_EMPTY;
    endcase
    // an output beat in the flush cycle has already been sampled downstream
    if (flush) next_state = PSK_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PSK_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != PSK_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign main_in_data = main_from_skid ? skid_data : in_data;
  assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .drop   (main_drop),
    .load   (main_load),
    .in_data(main_in_data),
    .in_ctrl(main_in_ctrl),
    .valid  (main_valid),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .drop   (skid_drop),
    .load   (skid_load),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .valid  (skid_valid),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized queue-model bench for pipe_stage_skid
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [15:0] out_data0, out_data1;
  logic [7:0]  out_ctrl0, out_ctrl1;
  logic [1:0]  occ0, occ1;
  logic [2:0]  stall0;
  logic [15:0] stall1;

  beat_t       q[$];
  int          st0, st1;
  logic [15:0] hold0, hold1;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_cnt(stall0)
  );

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .CLEAR_DATA(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_cnt(stall1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] ec;
    ec = (q.size() > 0) ? q[0].c : 8'h00;
    check("in_ready0", in_ready0, q.size() < 2);
    check("in_ready1", in_ready1, q.size() < 2);
    check("out_valid0", out_valid0, q.size() > 0);
    check("out_valid1", out_valid1, q.size() > 0);
    check("occupancy0", occ0, q.size());
    check("occupancy1", occ1, q.size());
    check("out_ctrl0", out_ctrl0, ec);
    check("out_ctrl1", out_ctrl1, ec);
    check("out_data0", out_data0, hold0);
    check("out_data1", out_data1, hold1);
    check("stall_cnt0", stall0, st0);
    check("stall_cnt1", stall1, st1);
  endtask

  // one clock: drive inputs, advance the queue model across the edge, compare
  task automatic cycle(input logic r, input logic fl, input logic iv,
                       input logic [15:0] d, input logic [7:0] c, input logic ordy);
    int  pre;
    logic in_x, out_x;
    rst = r; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    pre   = q.size();
    in_x  = iv && (pre < 2);
    out_x = (pre > 0) && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      st0 = 0; st1 = 0; hold0 = 16'h0; hold1 = 16'h0;
    end else begin
      if (pre > 0 && !ordy) begin
        if (st0 < 7) st0++;
        if (st1 < 65535) st1++;
      end
      if (fl) begin
        q.delete();
        hold1 = 16'h0;
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back('{d: d, c: c});
        if (q.size() > 0) begin
          hold0 = q[0].d;
          hold1 = q[0].d;
        end
      end
    end
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    st0 = 0; st1 = 0; hold0 = 0; hold1 = 0;

    cycle(1, 0, 0, 16'h0, 8'h0, 0);
    cycle(1, 0, 0, 16'h0, 8'h0, 0);
    check("reset_in_ready", in_ready0, 1'b1);
    check("reset_stall", stall1, 16'd0);

    // streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 16'(i), 8'(i + 16), 1);
      check("stream_data", out_data0, 16'(i));
    end
    cycle(0, 0, 0, 16'h0, 8'h0, 1);

    // back-pressure fills the skid slot
    cycle(0, 0, 1, 16'hA, 8'h3, 0);
    cycle(0, 0, 1, 16'hB, 8'h4, 0);
    check("skid_full_occ", occ0, 2'd2);
    check("skid_in_ready", in_ready0, 1'b0);
    cycle(0, 0, 1, 16'hEE, 8'h5, 0);
    check("skid_hold_a", out_data0, 16'hA);
    cycle(0, 0, 0, 16'h0, 8'h0, 1);
    check("drain_b", out_data0, 16'hB);
    cycle(0, 0, 0, 16'h0, 8'h0, 1);
    check("drained_ready", in_ready0, 1'b1);

    // flush while full, incoming beat dropped
    cycle(0, 0, 1, 16'h11, 8'hFF, 0);
    cycle(0, 0, 1, 16'h12, 8'hFF, 0);
    cycle(0, 1, 1, 16'hC, 8'hFF, 0);
    check("flush_ctrl", out_ctrl0, 8'h00);
    cycle(0, 0, 0, 16'h0, 8'h0, 1);
    cycle(0, 0, 1, 16'h21, 8'h1, 1);
    check("after_flush_accept", out_data0, 16'h21);

    // flush coinciding with an output transfer
    cycle(0, 0, 1, 16'hD, 8'h7, 0);
    cycle(0, 1, 0, 16'h0, 8'h0, 1);
    check("flush_out_empty", occ0, 2'd0);

    // saturation of the narrow counter, immune to flush, cleared by reset
    cycle(0, 0, 1, 16'h1234, 8'h9, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 16'h0, 8'h0, 0);
    check("stall_saturated", stall0, 3'd7);
    cycle(0, 1, 0, 16'h0, 8'h0, 0);
    check("stall_after_flush", stall0, 3'd7);
    check("clear0_data_kept", out_data0, 16'h1234);
    check("clear1_data_zero", out_data1, 16'h0);
    cycle(1, 1, 1, 16'h55, 8'h1, 0);
    check("stall_after_rst", stall0, 3'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
            ($urandom_range(0, 4) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
